// File: rtl/cpu_pkg.sv
// Shared types and constants for the redirection-pipeline MIPS CPU.
package cpu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [DATA_W-1:0] SYSCALL_DISPLAY_DEFAULT = 32'd34;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

endpackage

// File: rtl/data_ram.sv
// Data RAM: asynchronous read, synchronous write with per-half write enables {upper, lower}.
module data_ram
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (we[1]) mem[idx][31:16] <= wdata[31:16];
    if (we[0]) mem[idx][15:0]  <= wdata[15:0];
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data RAM access, syscall RUN/HALT FSM, writeback mux and optional
// retire/memory-op counters (enabled by defining MEM_STAGE_STATS_EN).
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH      = 10,
  parameter logic [DATA_W-1:0] SYSCALL_DISPLAY = SYSCALL_DISPLAY_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  Eff,
  input  logic [DATA_W-1:0]     AluResult,
  input  logic [DATA_W-1:0]     R1,
  input  logic [DATA_W-1:0]     R2,
  input  logic [DATA_W-1:0]     PC_plus_four,
  input  logic                  MemWrite,
  input  logic                  MemToReg,
  input  logic                  HalfW,
  input  logic                  JAL,
  input  logic                  RegWrite,
  input  logic                  Syscall,
  input  logic [REG_ADDR_W-1:0] WAdr,
  input  logic                  Go,
  output logic [DATA_W-1:0]     WData,
  output logic [REG_ADDR_W-1:0] WAdr_Out,
  output logic                  RegWrite_Out,
  output logic                  Halt,
  output logic [DATA_W-1:0]     LedData,
  output logic [DATA_W-1:0]     RetireCount,
  output logic [DATA_W-1:0]     MemOpCount
);

  state_t                state;
  logic                  act;
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            ram_we;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;
  logic [DATA_W-1:0]     rd;
  logic [15:0]           half;

  assign act  = Eff & (state == RUN);
  assign idx  = AluResult[ADDR_WIDTH+1:2];
  assign hsel = AluResult[1];

  // Halfword store replicates R2[15:0] into both halves; the enable picks which lands.
  always_comb begin
    ram_we    = '0;
    ram_wdata = R2;
    if (act & MemWrite) begin
      if (HalfW) begin
        ram_we    = hsel ? 2'b10 : 2'b01;
        ram_wdata = {R2[15:0], R2[15:0]};
      end else begin
        ram_we = 2'b11;
      end
    end
  end

  data_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .idx  (idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    half = hsel ? ram_rdata[31:16] : ram_rdata[15:0];
    rd   = HalfW ? {{16{half[15]}}, half} : ram_rdata;
    if (JAL)           WData = PC_plus_four;
    else if (MemToReg) WData = rd;
    else               WData = AluResult;
  end

  assign WAdr_Out     = WAdr;
  assign RegWrite_Out = RegWrite & act;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= RUN;
      Halt    <= 1'b0;
      LedData <= '0;
    end else begin
      case (state)
        RUN: begin
          if (act & Syscall) begin
            if (R1 == SYSCALL_DISPLAY) begin
              LedData <= R2;
            end else begin
              state <= HALT;
              Halt  <= 1'b1;
            end
          end
        end
        HALT: begin
          if (Go) begin
            state <= RUN;
            Halt  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          Halt  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_STAGE_STATS_EN
  logic [DATA_W-1:0] retire_cnt;
  logic [DATA_W-1:0] memop_cnt;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      retire_cnt <= '0;
      memop_cnt  <= '0;
    end else if (act) begin
      retire_cnt <= retire_cnt + 1'b1;
      if (MemWrite | MemToReg) memop_cnt <= memop_cnt + 1'b1;
    end
  end

  assign RetireCount = retire_cnt;
  assign MemOpCount  = memop_cnt;
`else
  assign RetireCount = '0;
  assign MemOpCount  = '0;
`endif

endmodule
